zcu216_clk_reset_seq: RTL and testbench

ZCU216_CLK_RESET_SEQ -- requirements
Module: zcu216_clk_reset_seq

---
 rtl/zcu216_clk_reset_seq.sv | 76 +++++++
 tb/tb_zcu216_clk_reset_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/zcu216_clk_reset_seq.sv
// zcu216_clk_reset_seq: qualifies MMCM lock, sequences the downstream DSP reset and counts lock losses
//    adc_clk       : sole clock (BUFG'd MMCM CLKOUT0)
//    adc_rst       : synchronous active-high reset
//    mmcm_locked   : MMCM LOCKED, asynchronous to adc_clk
//    sw_rst        : single-cycle request to re-run the hold phase (honoured in RUN only)
//    cnt_clr       : synchronous clear of lock_loss_cnt
//    dsp_rst       : active-high reset for downstream DSP logic
//    clk_ready     : clocks qualified and dsp_rst released
//    lock_sync     : mmcm_locked after a 2-flop synchronizer
//    state         : FSM state (WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3)
//    lock_loss_cnt : saturating count of lock losses seen in RUN
module zcu216_clk_reset_seq #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RST_HOLD_CYCLES    = 256,
   parameter int CNT_W              = 16
) (
   input  logic             adc_clk,
   input  logic             adc_rst,
   input  logic             mmcm_locked,
   input  logic             sw_rst,
   input  logic             cnt_clr,
   output logic             dsp_rst,
   output logic             clk_ready,
   output logic             lock_sync,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] lock_loss_cnt
);
   typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
   localparam int MAX_C = LOCK_STABLE_CYCLES > RST_HOLD_CYCLES ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
   localparam int CW = $clog2(MAX_C + 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
   state_t cur, nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic meta, loss;
   always_comb begin
      nxt  = cur;
      loss = 1'b0;
      case (cur)
         WAIT_LOCK: nxt = lock_sync ? STABLE : WAIT_LOCK;
         STABLE:    nxt = !lock_sync ? WAIT_LOCK : (cnt == STABLE_LAST ? HOLD : STABLE);
         HOLD:      nxt = !lock_sync ? WAIT_LOCK : (cnt == HOLD_LAST ? RUN : HOLD);
         RUN: begin
            loss = !lock_sync;
            nxt  = loss ? WAIT_LOCK : (sw_rst ? HOLD : RUN);
         end
         default:   nxt = WAIT_LOCK;
      endcase
      // any state change (including RUN->HOLD on sw_rst) restarts the phase counter
      cnt_nxt = (nxt == cur && (cur == STABLE || cur == HOLD)) ? cnt + 1'b1 : '0;
   end
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         meta          <= 1'b0;
         lock_sync     <= 1'b0;
         cur           <= WAIT_LOCK;
         cnt           <= '0;
         dsp_rst       <= 1'b1;
         clk_ready     <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         meta      <= mmcm_locked;
         lock_sync <= meta;
         cur       <= nxt;
         cnt       <= cnt_nxt;
         // decoded from next state so the outputs move on the same edge as state
         dsp_rst   <= nxt != RUN;
         clk_ready <= nxt == RUN;
         if (cnt_clr)
            lock_loss_cnt <= loss ? CNT_W'(1) : '0;
         else if (loss && lock_loss_cnt != '1)
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
   end
   assign state = cur;
endmodule

// File: tb/tb_zcu216_clk_reset_seq.sv
// tb_zcu216_clk_reset_seq: directed + randomized check of zcu216_clk_reset_seq against a lock-age model
module tb_zcu216_clk_reset_seq;
   localparam int L = 8;
   localparam int H = 4;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst = 1'b1, ml = 1'b0, sw = 1'b0, clr = 1'b0;
   logic dsp_rst, clk_ready, lock_sync;
   logic [1:0] state;
   logic [W-1:0] llc;
   int errors = 0;
   int checks = 0;
   int m_s1 = 0, m_s2 = 0, m_age = 0, m_llc = 0;
   always #5 clk = ~clk;
   zcu216_clk_reset_seq #(.LOCK_STABLE_CYCLES(L), .RST_HOLD_CYCLES(H), .CNT_W(W)) dut (
      .adc_clk(clk), .adc_rst(rst), .mmcm_locked(ml), .sw_rst(sw), .cnt_clr(clr),
      .dsp_rst(dsp_rst), .clk_ready(clk_ready), .lock_sync(lock_sync),
      .state(state), .lock_loss_cnt(llc)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask
   // the model tracks only how long lock_sync has been continuously high;
   // the sequencer phase follows from that age alone
   function automatic int m_state();
      return m_age == 0 ? 0 : m_age <= L ? 1 : m_age <= L + H ? 2 : 3;
   endfunction
   task automatic step();
      int ls;
      bit in_run, loss;
      @(posedge clk);
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_age = 0; m_llc = 0;
      end else begin
         ls     = m_s2;
         in_run = m_age > L + H;
         loss   = in_run && ls == 0;
         if (ls == 0) m_age = 0;
         else if (in_run && sw) m_age = L + 1;
         else m_age = (m_age + 1 > L + H + 1) ? L + H + 1 : m_age + 1;
         if (clr) m_llc = loss ? 1 : 0;
         else if (loss && m_llc < (1 << W) - 1) m_llc++;
         m_s2 = m_s1;
         m_s1 = int'(ml);
      end
      #1;
      chk("state", 32'(state), 32'(m_state()));
      chk("dsp_rst", 32'(dsp_rst), 32'(m_state() != 3));
      chk("clk_ready", 32'(clk_ready), 32'(m_state() == 3));
      chk("lock_sync", 32'(lock_sync), 32'(m_s2));
      chk("lock_loss_cnt", 32'(llc), 32'(m_llc));
   endtask
   task automatic steps(input int n);
      repeat (n) step();
   endtask
   task automatic time_to_ready(input string tag);
      int n = 0;
      while (!clk_ready && n < 100) begin
         step();
         n++;
      end
      chk(tag, n, 15);
   endtask
   initial begin
      int n;
      steps(3);
      chk("reset_dsp_rst", 32'(dsp_rst), 1);
      chk("reset_state", 32'(state), 0);
      rst = 1'b0;
      steps(2);
      ml = 1'b1;
      time_to_ready("lock_to_run");
      steps(3);
      sw = 1'b1;
      n = 0;
      repeat (7) begin
         step();
         sw = 1'b0;
         n += int'(dsp_rst);
      end
      chk("sw_hold_len", n, 4);
      sw = 1'b1;
      n = 0;
      repeat (7) begin
         step();
         sw = (n == 0) ? 1'b1 : 1'b0;
         n += int'(dsp_rst);
      end
      chk("sw_in_hold_ignored", n, 4);
      sw = 1'b0;
      ml = 1'b0;
      n = 0;
      while (!dsp_rst && n < 20) begin
         step();
         n++;
      end
      chk("loss_latency", n, 3);
      chk("first_loss_cnt", 32'(llc), 1);
      steps(3);
      ml = 1'b1;
      steps(9);
      chk("glitch_in_stable", 32'(state), 1);
      ml = 1'b0;
      steps(3);
      ml = 1'b1;
      time_to_ready("glitch_requal");
      chk("glitch_no_count", 32'(llc), 1);
      repeat (16) begin
         ml = 1'b1;
         steps(16);
         ml = 1'b0;
         steps(3);
      end
      chk("saturate", 32'(llc), 15);
      ml = 1'b1;
      steps(16);
      ml = 1'b0;
      steps(2);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_with_loss", 32'(llc), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_alone", 32'(llc), 0);
      ml = 1'b1;
      steps(12);
      chk("in_hold", 32'(state), 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_in_hold_state", 32'(state), 0);
      chk("rst_in_hold_dsp", 32'(dsp_rst), 1);
      time_to_ready("post_rst_requal");
      repeat (3000) begin
         if ($urandom_range(0, 19) == 0) ml = ~ml;
         sw  = $urandom_range(0, 15) == 0;
         clr = $urandom_range(0, 31) == 0;
         rst = $urandom_range(0, 199) == 0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
